// File: rtl/tuner_phy_ctrl_arb_multi.sv
// tuner_phy_ctrl_arb_multi: NUM_CH-way arbiter sequencing shared tuner DAC updates and power detects
module tuner_phy_ctrl_arb_multi #(
   parameter int NUM_CH         = 4,
   parameter int CODE_WIDTH     = 8,
   parameter int PWR_WIDTH      = 8,
   parameter int SETTLE_CYCLES  = 4,
   parameter int DETECT_TIMEOUT = 64,
   parameter int PRIO_MODE      = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            i_req,
   input  logic [NUM_CH*CODE_WIDTH-1:0] i_code,
   output logic [NUM_CH-1:0]            o_gnt,
   output logic [CODE_WIDTH-1:0]        o_tuner_code,
   output logic                         o_tuner_valid,
   output logic                         o_detect_req,
   input  logic                         i_detect_valid,
   input  logic [PWR_WIDTH-1:0]         i_detect_pwr,
   output logic [NUM_CH-1:0]            o_rsp_valid,
   output logic [CODE_WIDTH-1:0]        o_rsp_code,
   output logic [PWR_WIDTH-1:0]         o_rsp_pwr,
   output logic                         o_rsp_err,
   output logic [1:0]                   o_state
);
   localparam int IW = $clog2(NUM_CH);
   localparam int SW = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int TW = $clog2(DETECT_TIMEOUT + 1);
   typedef enum logic [1:0] {INIT = 2'b00, TUNE = 2'b01, SYNC = 2'b10, COMMIT = 2'b11} state_t;
   state_t                state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d, win_q, win_d, sel, base;
   logic [CODE_WIDTH-1:0] code_q, code_d;
   logic [SW-1:0]         settle_q, settle_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [PWR_WIDTH-1:0]  pwr_q, pwr_d;
   logic                  err_q, err_d, any;
   logic [NUM_CH-1:0]     onehot;
   // Pick the first requester at or after base; walking downward lets the smallest offset overwrite
   always_comb begin
      base = PRIO_MODE != 0 ? '0 : ptr_q;
      sel  = '0;
      any  = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (i_req[IW'((int'(base) + i) % NUM_CH)]) begin
            sel = IW'((int'(base) + i) % NUM_CH);
            any = 1'b1;
         end
      end
   end
   // Transaction sequencer: latch winner, update DAC, settle, detect with timeout, respond
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      code_d   = code_q;
      settle_d = settle_q;
      tmo_d    = tmo_q;
      pwr_d    = pwr_q;
      err_d    = err_q;
      case (state_q)
         INIT: if (any) begin
            win_d   = sel;
            code_d  = i_code[int'(sel)*CODE_WIDTH +: CODE_WIDTH];
            state_d = TUNE;
         end
         TUNE: begin
            settle_d = SW'(SETTLE_CYCLES);
            tmo_d    = '0;
            state_d  = SYNC;
         end
         SYNC: begin
            if (settle_q != '0) settle_d = settle_q - SW'(1);
            else if (i_detect_valid) begin
               pwr_d   = i_detect_pwr;
               err_d   = 1'b0;
               state_d = COMMIT;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (tmo_d == TW'(DETECT_TIMEOUT)) begin
                  pwr_d   = '0;
                  err_d   = 1'b1;
                  state_d = COMMIT;
               end
            end
         end
         default: begin
            ptr_d   = int'(win_q) == NUM_CH - 1 ? '0 : win_q + IW'(1);
            state_d = INIT;
         end
      endcase
   end
   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= INIT;
         ptr_q    <= '0;
         win_q    <= '0;
         code_q   <= '0;
         settle_q <= '0;
         tmo_q    <= '0;
         pwr_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         code_q   <= code_d;
         settle_q <= settle_d;
         tmo_q    <= tmo_d;
         pwr_q    <= pwr_d;
         err_q    <= err_d;
      end
   end
   // Outputs decoded from registered state so they are glitch-free per cycle
   always_comb begin
      onehot        = NUM_CH'(1) << win_q;
      o_gnt         = state_q != INIT ? onehot : '0;
      o_rsp_valid   = state_q == COMMIT ? onehot : '0;
      o_rsp_code    = state_q == COMMIT ? code_q : '0;
      o_rsp_pwr     = state_q == COMMIT ? pwr_q : '0;
      o_rsp_err     = state_q == COMMIT ? err_q : 1'b0;
      o_tuner_code  = code_q;
      o_tuner_valid = state_q == TUNE;
      o_detect_req  = state_q == SYNC && settle_q == '0;
      o_state       = state_q;
   end
endmodule

// File: doc/tuner_phy_ctrl_arb_multi.md
Name: tuner_phy_ctrl_arb_multi

Overview:
- Parametrised successor to the two-channel (search/lock) tuner control arbiter.
- Arbitrates NUM_CH controller channels for one shared tuner DAC and power detector, in round-robin or fixed-priority mode.
- Runs each grant through INIT -> TUNE -> SYNC -> COMMIT, so every returned power reading is tied to the code that produced it.
- Adds a detect timeout with an error response. Sits between the per-ring search/lock controllers and the tuner/detect PHY.

Parameters:
- NUM_CH, 4: number of requesting channels (>=2).
- CODE_WIDTH, 8: tuner code width.
- PWR_WIDTH, 8: power reading width.
- SETTLE_CYCLES, 4: cycles waited in SYNC after the code update before requesting a detect (0 allowed).
- DETECT_TIMEOUT, 64: maximum cycles o_detect_req may stay high without i_detect_valid (>=1).
- PRIO_MODE, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- i_req  in  NUM_CH  per-channel request, level.
- i_code  in  NUM_CH*CODE_WIDTH  per-channel requested code; channel k occupies bits [k*CODE_WIDTH +: CODE_WIDTH].
- o_gnt  out  NUM_CH  one-hot grant, held TUNE through COMMIT.
- o_tuner_code  out  CODE_WIDTH  code applied to the DAC; holds its last value.
- o_tuner_valid  out  1  one-cycle update strobe.
- o_detect_req  out  1  power-detect request, level.
- i_detect_valid  in  1  detect result valid.
- i_detect_pwr  in  PWR_WIDTH  detect result.
- o_rsp_valid  out  NUM_CH  one-cycle response strobe to the granted channel.
- o_rsp_code  out  CODE_WIDTH  code that was measured.
- o_rsp_pwr  out  PWR_WIDTH  measured power; 0 on error.
- o_rsp_err  out  1  response is a timeout; qualified by o_rsp_valid.
- o_state  out  2  current state: INIT=00, TUNE=01, SYNC=10, COMMIT=11.

Behaviour:
- Reset values: state INIT, RR pointer 0, all outputs 0 (including o_tuner_code), all counters 0.

State machine:
- INIT: if any i_req bit is high, select the winner and latch its i_code, then go to TUNE. Otherwise stay.
  - Round-robin: first requester scanning upward from the pointer, wrapping at NUM_CH-1 -> 0.
  - Fixed priority: lowest set index.
- TUNE (exactly 1 cycle): o_gnt = one-hot(winner), o_tuner_code = latched code, o_tuner_valid = 1. Load settle counter = SETTLE_CYCLES, then go to SYNC.
- SYNC:
  - While the settle counter > 0, decrement it; o_detect_req = 0.
  - When it reaches 0, o_detect_req = 1 and the timeout counter increments each cycle.
  - i_detect_valid sampled high with o_detect_req high: capture i_detect_pwr, set err = 0, go to COMMIT.
  - Timeout counter reaches DETECT_TIMEOUT without a valid: pwr = 0, err = 1, go to COMMIT.
  - If valid and timeout occur in the same cycle, the valid wins.
- COMMIT (exactly 1 cycle):
  - o_rsp_valid[winner] = 1, with o_rsp_code, o_rsp_pwr and o_rsp_err driven.
  - o_gnt stays high this cycle and clears on exit.
  - RR pointer = (winner+1) mod NUM_CH; the pointer is unused in PRIO_MODE=1.
  - Go to INIT.

Timing:
- Request seen in INIT at cycle 0: grant and strobe at cycle 1, SYNC entered at cycle 2, o_detect_req first high at cycle 2+SETTLE_CYCLES.
- Valid at cycle t: response at t+1, INIT at t+2. A new grant is possible no earlier than t+3.

Boundary rules:
- i_req and i_code are sampled only in INIT. A requester dropping i_req or changing i_code mid-transaction has no effect; the transaction completes.
- i_detect_valid while o_detect_req = 0 is ignored.
- Only one channel is granted at a time; o_gnt and o_rsp_valid are never multi-hot.
- Reset asserted mid-transaction returns everything to reset values; no response is issued.
- All width arithmetic is unsigned. Counters are sized to clog2(max parameter + 1).

Test Plan:
1. Single channel: NUM_CH=4, SETTLE_CYCLES=4, i_req=0010, code[1]=8'hA5, detect valid with pwr=8'h3C two cycles after o_detect_req rises.
   -> o_gnt=0010 at cycle 1; o_tuner_valid pulse with code A5; o_detect_req at cycle 6; o_rsp_valid=0010, o_rsp_code=A5, o_rsp_pwr=3C, o_rsp_err=0 at cycle 9.
2. Round-robin: PRIO_MODE=0, i_req=1111 held, immediate detect valid.
   -> grants appear in order 0001, 0010, 0100, 1000, 0001.
3. Fixed priority: PRIO_MODE=1, i_req=1110 held.
   -> every grant is 0010.
4. Timeout: DETECT_TIMEOUT=8, no i_detect_valid.
   -> o_detect_req high for exactly 8 cycles; o_rsp_err=1, o_rsp_pwr=0; returns to INIT.
5. Zero settle and stray inputs: SETTLE_CYCLES=0; i_detect_valid pulsed during TUNE.
   -> stray pulse ignored; o_detect_req high in the first SYNC cycle.
6. Reset mid-transaction: drop rst_n while in SYNC.
   -> immediately o_state=00, o_gnt=0, o_tuner_code=0, no o_rsp_valid; the next request is granted normally.
